// File: rtl/mdu_pkg.sv
// Shared types and sizing for the multiply/divide unit.
// MDU_MADD_EN widens the op code by one extension bit and adds MADD/MADDU/MSUB/MSUBU.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(MDU_WIDTH);

`ifdef MDU_MADD_EN
  localparam int unsigned OP_W = 4;
`else
  localparam int unsigned OP_W = 3;
`endif

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = OP_W'(0),
    OP_MULT  = OP_W'(1),
    OP_MULTU = OP_W'(2),
    OP_DIV   = OP_W'(3),
    OP_DIVU  = OP_W'(4),
    OP_MTHI  = OP_W'(5),
`ifdef MDU_MADD_EN
    OP_MTLO  = OP_W'(6),
    // Extension bit set selects the multiply-accumulate family.
    OP_MADD  = OP_W'(8),
    OP_MADDU = OP_W'(9),
    OP_MSUB  = OP_W'(10),
    OP_MSUBU = OP_W'(11)
`else
    OP_MTLO  = OP_W'(6)
`endif
  } op_e;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/result bundle between execute-stage control and the MDU.
interface mdu_hilo_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
);
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_div_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Results are presented combinationally on the cycle fin is high.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial_s, diff_s;
  logic             ge_s, fin_s;
  logic [WIDTH-1:0] rem_step_s, quo_step_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // quo_q holds the not-yet-consumed dividend bits at the top and the quotient bits at the bottom.
  always_comb begin
    trial_s    = {rem_q, quo_q[WIDTH-1]};
    diff_s     = trial_s - {1'b0, dvsr_q};
    ge_s       = ~diff_s[WIDTH];
    rem_step_s = ge_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    quo_step_s = {quo_q[WIDTH-2:0], ge_s};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    fin_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          state_d = DIV_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = neg_if(dividend, signed_op & dividend[WIDTH-1]);
          dvsr_d  = neg_if(divisor, signed_op & divisor[WIDTH-1]);
          qneg_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = signed_op & dividend[WIDTH-1];
          dz_d    = (divisor == '0);
        end else begin
          state_d = IDLE;
        end
      end
      DIV_RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_step_s;
          quo_d = quo_step_s;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            fin_s   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  // Divide by zero yields all-ones quotient; remainder correction alone restores the raw dividend.
  assign busy = (state_q == DIV_RUN);
  assign fin  = fin_s;
  assign quo  = dz_q ? {WIDTH{1'b1}} : neg_if(quo_step_s, qneg_q);
  assign rem  = neg_if(rem_step_s, rneg_q);

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers and single-cycle multiply.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  mdu_hilo_if.slave bus
);
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               accept_s;
  logic               mul_signed_s;
  logic               div_start_s, div_signed_s;
  logic               div_busy_s, div_fin_s;
  logic [WIDTH-1:0]   div_quo_s, div_rem_s;
  logic [2*WIDTH-1:0] prod_s;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_s;
  logic               acc_sub_s;
`endif

  function automatic logic [2*WIDTH-1:0] ext2(input logic [WIDTH-1:0] v, input logic sgn);
    return {{WIDTH{sgn & v[WIDTH-1]}}, v};
  endfunction

  // Extending both operands to 2*WIDTH makes one truncated multiply serve signed and unsigned.
  always_comb begin
    mul_signed_s = 1'b0;
    case (bus.op)
      OP_MULT: mul_signed_s = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: mul_signed_s = 1'b1;
`endif
      default: mul_signed_s = 1'b0;
    endcase
    prod_s = ext2(bus.a, mul_signed_s) * ext2(bus.b, mul_signed_s);
  end

`ifdef MDU_MADD_EN
  always_comb begin
    acc_sub_s = (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
    acc_s     = acc_sub_s ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
  end
`endif

  // New requests are taken only while the divider is idle and no flush is signalled.
  always_comb begin
    accept_s     = bus.start && !bus.cancel && !div_busy_s;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    div_start_s  = 1'b0;
    div_signed_s = 1'b0;
    if (div_fin_s) begin
      hi_d   = div_rem_s;
      lo_d   = div_quo_s;
      done_d = 1'b1;
    end else if (accept_s) begin
      case (bus.op)
        OP_MULT, OP_MULTU: begin
          {hi_d, lo_d} = prod_s;
          done_d       = 1'b1;
        end
        OP_MTHI: begin
          hi_d   = bus.a;
          done_d = 1'b1;
        end
        OP_MTLO: begin
          lo_d   = bus.a;
          done_d = 1'b1;
        end
        OP_DIV: begin
          div_start_s  = 1'b1;
          div_signed_s = 1'b1;
        end
        OP_DIVU: begin
          div_start_s  = 1'b1;
          div_signed_s = 1'b0;
        end
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
          {hi_d, lo_d} = acc_s;
          done_d       = 1'b1;
        end
`endif
        default: begin
          done_d = 1'b0;
        end
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .signed_op(div_signed_s),
    .cancel   (bus.cancel),
    .dividend (bus.a),
    .divisor  (bus.b),
    .busy     (div_busy_s),
    .fin      (div_fin_s),
    .quo      (div_quo_s),
    .rem      (div_rem_s)
  );

  assign bus.busy = div_busy_s;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
